lcd_frame_writer: RTL

//  Parametrised successor to the fixed 4x20 LCD path: one block runs the HD44780 power-on init, then owns a

---
 rtl/lcd_pkg.sv | 40 ++++
 rtl/lcd_bus_xact.sv | 70 +++++++
 rtl/lcd_frame_writer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - HD44780 command set, FSM state encodings and shared ASCII constants
package lcd_pkg;

  localparam logic [7:0] CMD_FUNC_8B2L = 8'h38;
  localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_ENTRY     = 8'h06;
  localparam logic [7:0] CMD_SET_DDRAM = 8'h80;

  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] CHAR_MINUS = 8'h2D;
  localparam logic [7:0] CHAR_DOT   = 8'h2E;
  localparam logic [7:0] CHAR_ZERO  = 8'h30;
  localparam logic [7:0] CHAR_E     = 8'h45;

  localparam logic [2:0] ST_POWER_WAIT = 3'd0;
  localparam logic [2:0] ST_INIT       = 3'd1;
  localparam logic [2:0] ST_IDLE       = 3'd2;
  localparam logic [2:0] ST_SET_ADDR   = 3'd3;
  localparam logic [2:0] ST_WRITE_CHAR = 3'd4;
  localparam logic [2:0] ST_NEXT_LINE  = 3'd5;

  localparam logic [1:0] XS_IDLE  = 2'd0;
  localparam logic [1:0] XS_SETUP = 2'd1;
  localparam logic [1:0] XS_PULSE = 2'd2;
  localparam logic [1:0] XS_HOLD  = 2'd3;

  localparam int INIT_LEN = 7;

  // Function set is repeated four times so the controller locks into 8-bit mode from any state.
  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2, 3'd3: init_cmd = CMD_FUNC_8B2L;
      3'd4:                   init_cmd = CMD_DISP_ON;
      3'd5:                   init_cmd = CMD_CLEAR;
      default:                init_cmd = CMD_ENTRY;
    endcase
  endfunction

endpackage

// File: rtl/lcd_bus_xact.sv
// rtl/lcd_bus_xact.sv - one panel bus write: SETUP, enable PULSE, then HOLD wait
module lcd_bus_xact import lcd_pkg::*; #(
  parameter int T_E     = 25,
  parameter int T_CMD   = 2_500,
  parameter int T_CLEAR = 100_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] data,
  input  logic       long_wait,
  output logic       busy,
  output logic       done,
  output logic       lcd_rs,
  output logic       lcd_e,
  output logic [7:0] lcd_data
);

  logic [1:0]  state;
  logic [31:0] cnt;
  logic        long_q;
  logic [31:0] hold_last;

  assign hold_last = long_q ? 32'(T_CLEAR - 1) : 32'(T_CMD - 1);
  assign busy      = (state != XS_IDLE);
  assign done      = (state == XS_HOLD) && (cnt == hold_last);

  // rs/data are captured at start and held until the next start, so they are stable through HOLD.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= XS_IDLE;
      cnt      <= '0;
      long_q   <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_e    <= 1'b0;
      lcd_data <= 8'h00;
    end else begin
      case (state)
        XS_IDLE: begin
          if (start) begin
            state    <= XS_SETUP;
            lcd_rs   <= rs;
            lcd_data <= data;
            long_q   <= long_wait;
          end
        end
        XS_SETUP: begin
          state <= XS_PULSE;
          lcd_e <= 1'b1;
          cnt   <= '0;
        end
        XS_PULSE: begin
          if (cnt == 32'(T_E - 1)) begin
            state <= XS_HOLD;
            lcd_e <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1;
          end
        end
        default: begin
          if (done) state <= XS_IDLE;
          else      cnt   <= cnt + 1;
        end
      endcase
    end
  end

endmodule

// File: rtl/lcd_frame_writer.sv
// rtl/lcd_frame_writer.sv - HD44780 init plus LINES x CHARS frame buffer streamer
// Optional LCD_DIRTY_SKIP_EN: rewrite only dirty lines instead of round-robin refresh.
module lcd_frame_writer import lcd_pkg::*; #(
  parameter int         LINES          = 4,
  parameter int         CHARS          = 20,
  parameter logic [6:0] LINE_STARTS [4] = '{7'h00, 7'h40, 7'h14, 7'h54},
  parameter int         T_POWER        = 750_000,
  parameter int         T_CMD          = 2_500,
  parameter int         T_CLEAR        = 100_000,
  parameter int         T_E            = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [1:0] wr_line,
  input  logic [5:0] wr_col,
  input  logic [7:0] wr_char,
  output logic       wr_err,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic       init_done
);

  localparam int LW = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int CW = (CHARS > 1) ? $clog2(CHARS) : 1;

  logic [2:0]    state;
  logic [31:0]   cnt;
  logic [2:0]    init_idx;
  logic          issued;
  logic [LW-1:0] cur_line;
  logic [CW-1:0] col;
  logic [7:0]    buf_mem [LINES][CHARS];

  logic       xact_start, xact_rs, xact_long, xact_busy, xact_done;
  logic [7:0] xact_data;
  logic       wr_fire, wr_ok;

  assign wr_ready = init_done && !reset;
  assign wr_fire  = wr_valid && wr_ready;
  assign wr_ok    = (32'(wr_line) < LINES) && (32'(wr_col) < CHARS);
  assign lcd_rw   = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LINES; i++)
        for (int j = 0; j < CHARS; j++)
          buf_mem[i][j] <= CHAR_SPACE;
      wr_err <= 1'b0;
    end else begin
      if (wr_fire && wr_ok) buf_mem[wr_line[LW-1:0]][wr_col[CW-1:0]] <= wr_char;
      wr_err <= wr_fire && !wr_ok;
    end
  end

`ifdef LCD_DIRTY_SKIP_EN
  logic [LINES-1:0] dirty;
  logic [LW-1:0]    pick;

  always_comb begin
    pick = '0;
    for (int i = LINES - 1; i >= 0; i--)
      if (dirty[i]) pick = LW'(i);
  end

  // A write landing on the line being cleared wins, so mid-stream edits trigger another pass.
  always_ff @(posedge clk) begin
    if (reset) begin
      dirty <= '1;
    end else begin
      if (state == ST_IDLE && |dirty) dirty[pick] <= 1'b0;
      if (wr_fire && wr_ok) dirty[wr_line[LW-1:0]] <= 1'b1;
    end
  end
`endif

  // Char data is read here at the start request, so each byte sent is a snapshot at SETUP.
  always_comb begin
    xact_rs    = 1'b0;
    xact_data  = 8'h00;
    xact_start = !xact_busy && !issued &&
                 (state == ST_INIT || state == ST_SET_ADDR || state == ST_WRITE_CHAR);
    case (state)
      ST_INIT:       xact_data = init_cmd(init_idx);
      ST_SET_ADDR:   xact_data = CMD_SET_DDRAM | {1'b0, LINE_STARTS[2'(cur_line)]};
      ST_WRITE_CHAR: begin
        xact_rs   = 1'b1;
        xact_data = buf_mem[cur_line][col];
      end
      default: ;
    endcase
    xact_long = (state == ST_INIT) && (xact_data == CMD_CLEAR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_POWER_WAIT;
      cnt       <= '0;
      init_idx  <= '0;
      issued    <= 1'b0;
      init_done <= 1'b0;
      cur_line  <= '0;
      col       <= '0;
    end else begin
      if (xact_start) issued <= 1'b1;
      if (xact_done)  issued <= 1'b0;
      case (state)
        ST_POWER_WAIT: begin
          if (cnt == 32'(T_POWER - 1)) state <= ST_INIT;
          else                         cnt   <= cnt + 1;
        end
        ST_INIT: begin
          if (xact_done) begin
            if (init_idx == 3'(INIT_LEN - 1)) begin
              state     <= ST_IDLE;
              init_done <= 1'b1;
            end else begin
              init_idx <= init_idx + 3'd1;
            end
          end
        end
        ST_IDLE: begin
`ifdef LCD_DIRTY_SKIP_EN
          if (|dirty) begin
            cur_line <= pick;
            state    <= ST_SET_ADDR;
          end
`else
          state <= ST_SET_ADDR;
`endif
        end
        ST_SET_ADDR: begin
          if (xact_done) begin
            col   <= '0;
            state <= ST_WRITE_CHAR;
          end
        end
        ST_WRITE_CHAR: begin
          if (xact_done) begin
            if (col == CW'(CHARS - 1)) state <= ST_NEXT_LINE;
            else                       col   <= col + 1'b1;
          end
        end
        default: begin
          cur_line <= (cur_line == LW'(LINES - 1)) ? '0 : cur_line + 1'b1;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  lcd_bus_xact #(
    .T_E     (T_E),
    .T_CMD   (T_CMD),
    .T_CLEAR (T_CLEAR)
  ) u_xact (
    .clk       (clk),
    .reset     (reset),
    .start     (xact_start),
    .rs        (xact_rs),
    .data      (xact_data),
    .long_wait (xact_long),
    .busy      (xact_busy),
    .done      (xact_done),
    .lcd_rs    (lcd_rs),
    .lcd_e     (lcd_e),
    .lcd_data  (lcd_data)
  );

endmodule
